isqrt_iter_responder: RTL and testbench

- Responder side of the isqrt request/result interface: accepts x_vld/x requests and returns y_vld/y = floor(sqrt(x)).
- Serves the formula FSMs (one instance per isqrt port) in place of a fully pipelined isqrt.
- Iterative restoring digit-by-digit algorithm producing one root bit per cycle.
- Small request FIFO absorbs requests that arrive while busy; results return in request order.

---
 rtl/isqrt_pkg.sv | 14 +
 rtl/isqrt_req_fifo.sv | 57 +++++
 rtl/isqrt_iter_responder.sv | 155 +++++++++++++++
 tb/tb_isqrt_iter_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and default widths for the iterative isqrt responder.
package isqrt_pkg;

    localparam int ISQRT_N_IN  = 32;
    localparam int ISQRT_N_OUT = ISQRT_N_IN / 2;
    localparam int ISQRT_REM_W = ISQRT_N_OUT + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } isqrt_state_e;

endpackage

// File: rtl/isqrt_req_fifo.sv
// Flip-flop request FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate count.
module isqrt_req_fifo
    import isqrt_pkg::*;
#(
    parameter int WIDTH = ISQRT_N_IN,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/isqrt_iter_responder.sv
// Iterative floor(sqrt(x)) responder: restoring digit-by-digit, one root bit
// per cycle, with an in-order request queue in front of the datapath.
module isqrt_iter_responder
    import isqrt_pkg::*;
#(
    parameter int N_IN       = ISQRT_N_IN,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_vld,
    input  logic [N_IN-1:0]   x,
    output logic              y_vld,
    output logic [N_IN/2-1:0] y,
    output logic              busy,
    output logic              overflow
);
    localparam int N_OUT = N_IN / 2;
    localparam int REM_W = N_OUT + 2;
    localparam int IW    = $clog2(N_OUT);

    isqrt_state_e     r_state;
    isqrt_state_e     w_state_nxt;
    logic [N_IN-1:0]  r_operand;
    logic [N_IN-1:0]  w_operand_nxt;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_rem_nxt;
    logic [N_OUT-1:0] r_root;
    logic [N_OUT-1:0] w_root_nxt;
    logic [IW-1:0]    r_iter;
    logic [IW-1:0]    w_iter_nxt;
    logic [N_OUT-1:0] r_y;
    logic [N_OUT-1:0] w_y_nxt;
    logic             r_y_vld;
    logic             w_y_vld_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;

    logic [N_IN-1:0]  w_fifo_head;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_load;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic             w_drop;
    logic [N_IN-1:0]  w_req;

    logic [REM_W-1:0] w_r2;
    logic [REM_W-1:0] w_trial;
    logic [REM_W-1:0] w_diff;
    logic             w_ge;
    logic [N_OUT-1:0] w_root_step;

    // The queue always has priority over x so results stay in request order.
    assign w_load   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                      (!w_fifo_empty || x_vld);
    assign w_pop    = w_load && !w_fifo_empty;
    assign w_bypass = w_load && w_fifo_empty;
    assign w_push   = x_vld && !w_bypass;
    assign w_drop   = w_push && w_fifo_full && !w_pop;
    assign w_req    = w_fifo_empty ? x : w_fifo_head;

    isqrt_req_fifo #(
        .WIDTH (N_IN),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (x),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // The shifted-in remainder drops rem's top two bits; if either was set the
    // true value already exceeds any trial, so it forces the subtract.
    assign w_r2        = {r_rem[REM_W-3:0], r_operand[N_IN-1 -: 2]};
    assign w_trial     = {r_root, 2'b01};
    assign w_ge        = (r_rem[REM_W-1 -: 2] != 2'b00) || (w_r2 >= w_trial);
    assign w_diff      = w_r2 - w_trial;
    assign w_root_step = {r_root[N_OUT-2:0], w_ge};

    // Next-state and datapath update for load, iterate and done.
    always_comb begin
        w_state_nxt    = r_state;
        w_operand_nxt  = r_operand;
        w_rem_nxt      = r_rem;
        w_root_nxt     = r_root;
        w_iter_nxt     = r_iter;
        w_y_nxt        = r_y;
        w_y_vld_nxt    = 1'b0;
        w_overflow_nxt = r_overflow | w_drop;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_load) begin
                    w_state_nxt   = ST_CALC;
                    w_operand_nxt = w_req;
                    w_rem_nxt     = {REM_W{1'b0}};
                    w_root_nxt    = {N_OUT{1'b0}};
                    w_iter_nxt    = IW'(N_OUT - 1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_operand_nxt = {r_operand[N_IN-3:0], 2'b00};
                w_rem_nxt     = w_ge ? w_diff : w_r2;
                w_root_nxt    = w_root_step;
                w_iter_nxt    = r_iter - IW'(1);
                if (r_iter == {IW{1'b0}}) begin
                    w_state_nxt = ST_DONE;
                    w_y_nxt     = w_root_step;
                    w_y_vld_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_operand  <= {N_IN{1'b0}};
            r_rem      <= {REM_W{1'b0}};
            r_root     <= {N_OUT{1'b0}};
            r_iter     <= {IW{1'b0}};
            r_y        <= {N_OUT{1'b0}};
            r_y_vld    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_operand  <= w_operand_nxt;
            r_rem      <= w_rem_nxt;
            r_root     <= w_root_nxt;
            r_iter     <= w_iter_nxt;
            r_y        <= w_y_nxt;
            r_y_vld    <= w_y_vld_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign y_vld    = r_y_vld;
    assign y        = r_y;
    assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_isqrt_iter_responder.sv
// Scoreboard bench for isqrt_iter_responder: expected roots are queued when a
// request is driven and compared in order as y_vld strobes appear.
module tb_isqrt_iter_responder;

    logic        clk;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;
    logic        overflow;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    logic [15:0] exp_q [$];
    int          when_q [$];

    isqrt_iter_responder #(
        .N_IN       (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x_vld    (x_vld),
        .x        (x),
        .y_vld    (y_vld),
        .y        (y),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        longint unsigned r;
        longint unsigned vv;
        vv = longint'(v);
        r  = longint'($sqrt(real'(vv)));
        while (r * r > vv) r = r - 1;
        while ((r + 1) * (r + 1) <= vv) r = r + 1;
        return r[15:0];
    endfunction

    // Scoreboard: every strobe must match the oldest outstanding request.
    always @(negedge clk) begin
        if (y_vld === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_y_vld cycle=%0d y=%0d required=no strobe", cyc, y);
            end else begin
                logic [15:0] e;
                int          w;
                e = exp_q.pop_front();
                w = when_q.pop_front();
                if (y !== e)
                    $display("FAIL result y=%0d required=%0d", y, e);
                else if (w >= 0 && cyc != w)
                    $display("FAIL latency strobe_cycle=%0d required=%0d", cyc, w);
                else
                    n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [31:0] v, input int when);
        exp_q.push_back(ref_sqrt(v));
        when_q.push_back(when);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && k < 600) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (k >= 600)
            $display("FAIL %s_drain outstanding=%0d busy=%b required=0/0", tag, exp_q.size(), busy);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; x_vld = 1'b0; x = 32'd0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (y_vld !== 1'b0) $display("FAIL reset_y_vld got=%b required=0", y_vld); else n_pass++;
        n_total++; if (y !== 16'd0) $display("FAIL reset_y got=%0d required=0", y); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", busy); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b required=0", overflow); else n_pass++;
    endtask

    task automatic test_zero();
        int t;
        int bad_busy;
        int bad_vld;
        bad_busy = 0; bad_vld = 0;
        step();
        t = cyc; x_vld = 1'b1; x = 32'd0; expect_req(32'd0, t + 17);
        for (int k = 1; k <= 20; k++) begin
            step();
            x_vld = 1'b0;
            @(negedge clk);
            if (busy !== ((k <= 17) ? 1'b1 : 1'b0)) bad_busy++;
            if (y_vld !== ((k == 17) ? 1'b1 : 1'b0)) bad_vld++;
        end
        n_total++; if (bad_busy != 0) $display("FAIL zero_busy_window bad_cycles=%0d required=0", bad_busy); else n_pass++;
        n_total++; if (bad_vld != 0) $display("FAIL zero_y_vld_window bad_cycles=%0d required=0", bad_vld); else n_pass++;
        wait_drain("zero");
    endtask

    task automatic test_values();
        logic [31:0] vals [3];
        vals[0] = 32'hFFFF_FFFF; vals[1] = 32'd1000000; vals[2] = 32'd999999;
        for (int i = 0; i < 3; i++) begin
            step();
            x_vld = 1'b1; x = vals[i]; expect_req(vals[i], cyc + 17);
            step();
            x_vld = 1'b0;
            wait_drain("values");
        end
        repeat (3) @(negedge clk);
        n_total++; if (y !== 16'd999) $display("FAIL y_hold got=%0d required=999", y); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t;
        step();
        t = cyc;
        x_vld = 1'b1; x = 32'd16; expect_req(32'd16, t + 17);
        step();
        x = 32'd17; expect_req(32'd17, t + 34);
        step();
        x_vld = 1'b0;
        wait_drain("back_to_back");
    endtask

    task automatic test_overflow();
        int t;
        step();
        t = cyc;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) step();
            x_vld = 1'b1; x = i * i;
            if (i <= 5) expect_req(i * i, t + 17 * i);
        end
        @(negedge clk);
        n_total++; if (overflow !== 1'b0) $display("FAIL overflow_early got=%b required=0", overflow); else n_pass++;
        step();
        x_vld = 1'b0;
        @(negedge clk);
        n_total++; if (overflow !== 1'b1) $display("FAIL overflow_set got=%b required=1", overflow); else n_pass++;
        wait_drain("overflow");
        n_total++; if (overflow !== 1'b1) $display("FAIL overflow_sticky got=%b required=1", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad_vld;
        bad_vld = 0;
        step();
        x_vld = 1'b1; x = 32'd100;
        step();
        x_vld = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (y_vld !== 1'b0) bad_vld++;
            step();
        end
        n_total++; if (bad_vld != 0) $display("FAIL reset_mid_y_vld strobes=%0d required=0", bad_vld); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_mid_busy got=%b required=0", busy); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_mid_overflow got=%b required=0", overflow); else n_pass++;
        x_vld = 1'b1; x = 32'd49; expect_req(32'd49, cyc + 17);
        step();
        x_vld = 1'b0;
        wait_drain("after_reset");
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [31:0] v;
        int          gap;
        int          k;
        int          stalls;
        stalls = 0;
        step();
        for (int i = 0; i < 2000; i++) begin
            k = 0;
            while (exp_q.size() >= 4 && k < 200) begin
                x_vld = 1'b0;
                step();
                k++;
            end
            if (k >= 200) stalls++;
            r = 64'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'(r * r);
                2: v = (r == 64'd0) ? 32'd0 : 32'(r * r - 64'd1);
                default: v = 32'($urandom_range(0, 1023));
            endcase
            x_vld = 1'b1; x = v; expect_req(v, -1);
            step();
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : $urandom_range(0, 1);
            if (gap > 0) begin
                x_vld = 1'b0;
                repeat (gap) step();
            end
        end
        x_vld = 1'b0;
        n_total++; if (stalls != 0) $display("FAIL random_stall timeouts=%0d required=0", stalls); else n_pass++;
        wait_drain("random");
        n_total++; if (overflow !== 1'b0) $display("FAIL random_overflow got=%b required=0", overflow); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
